// File: rtl/sobel_edge_stream_if.sv
// Pixel stream and gradient/edge result bundle for the Sobel edge stage.
// Latency: none (wires only); the producer drives pixel_in and the Sobel stage drives the results.
// Backpressure: none; one pixel is consumed on every clock. EDGE_THRESH_EN adds the thresh input.
interface sobel_edge_stream_if #(
    parameter int PRECISION = 16
);
    logic [7:0]                  pixel_in;
    logic signed [PRECISION-1:0] gx;
    logic signed [PRECISION-1:0] gy;
    logic [7:0]                  edge_out;
`ifdef EDGE_THRESH_EN
    logic [7:0]                  thresh;

    modport master (
        output pixel_in,
        output thresh,
        input  gx,
        input  gy,
        input  edge_out
    );

    modport slave (
        input  pixel_in,
        input  thresh,
        output gx,
        output gy,
        output edge_out
    );
`else
    modport master (
        output pixel_in,
        input  gx,
        input  gy,
        input  edge_out
    );

    modport slave (
        input  pixel_in,
        output gx,
        output gy,
        output edge_out
    );
`endif
endinterface

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: line-buffered window, |gx|+|gy| saturated to 8 bits.
// Latency: gx/gy one edge after the window, edge_out three edges after the window.
// Backpressure: none; a pixel is accepted on every non-reset edge.
// Optional build macro EDGE_THRESH_EN turns edge_out into a binary 0/255 map against bus.thresh.
// The interface instance must be built with the same PRECISION as this module.
module sobel_edge_stream #(
    parameter int WIDTH     = 800,
    parameter int PRECISION = 16
) (
    input  logic               clk,
    input  logic               reset,
    sobel_edge_stream_if.slave bus
);

    localparam int CNT_MAX = 2 * WIDTH + 2;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic signed [PRECISION-1:0] grad_t;

    generate
        if (PRECISION < 12) begin : g_precision_check
            $error("sobel_edge_stream: PRECISION must be at least 12");
        end
    endgenerate

    // Two cascaded WIDTH-deep delay lines; the output of each is exactly one line older.
    logic [7:0] line1 [WIDTH];
    logic [7:0] line2 [WIDTH];

    // win[r][c]: row 0 is the current line, column 0 is the newest pixel.
    logic [7:0] win [3][3];

    // Number of samples accepted since reset, saturating once every tap is populated.
    logic [CW-1:0] fill_cnt;
    logic          row1_ok;
    logic          row2_ok;

    grad_t gx_d;
    grad_t gy_d;
    grad_t gx_q;
    grad_t gy_q;
    grad_t mag_d;
    grad_t mag_q;
    logic [7:0] sat_d;
    logic [7:0] edge_d;
    logic [7:0] edge_q;

    function automatic grad_t zext(input logic [7:0] p);
        return grad_t'({{(PRECISION-8){1'b0}}, p});
    endfunction

    function automatic grad_t abs_g(input grad_t v);
        return v[PRECISION-1] ? -v : v;
    endfunction

    // A row tap is only loaded from a delay line once that line holds post-reset samples,
    // so stale buffer contents never reach the window. Older columns inherit the masking
    // by shifting, because the masked value was written when the same condition applied.
    assign row1_ok = (fill_cnt >= CW'(WIDTH));
    assign row2_ok = (fill_cnt >= CW'(2 * WIDTH));

    // Delay lines shift only on accepted samples; their contents are never cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            line1[0] <= bus.pixel_in;
            line2[0] <= line1[WIDTH-1];
            for (int i = 1; i < WIDTH; i++) begin
                line1[i] <= line1[i-1];
                line2[i] <= line2[i-1];
            end
        end
    end

    // Sliding window and fill counter; reset empties the window and restarts masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= 8'd0;
                end
            end
        end else begin
            win[0][0] <= bus.pixel_in;
            win[1][0] <= row1_ok ? line1[WIDTH-1] : 8'd0;
            win[2][0] <= row2_ok ? line2[WIDTH-1] : 8'd0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 1; c < 3; c++) begin
                    win[r][c] <= win[r][c-1];
                end
            end
            if (fill_cnt != CW'(CNT_MAX)) begin
                fill_cnt <= fill_cnt + CW'(1);
            end
        end
    end

    // Sobel kernels on the current window; range is +/-1020 so PRECISION >= 12 never overflows.
    always_comb begin
        gx_d = (zext(win[0][0]) + (zext(win[1][0]) <<< 1) + zext(win[2][0]))
             - (zext(win[0][2]) + (zext(win[1][2]) <<< 1) + zext(win[2][2]));
        gy_d = (zext(win[0][0]) + (zext(win[0][1]) <<< 1) + zext(win[0][2]))
             - (zext(win[2][0]) + (zext(win[2][1]) <<< 1) + zext(win[2][2]));
    end

    // Magnitude and round/threshold logic feeding the last two pipeline registers.
    always_comb begin
        mag_d = abs_g(gx_q) + abs_g(gy_q);
        sat_d = 8'd0;
        if (mag_q[PRECISION-1]) begin
            sat_d = 8'd0;
        end else if (mag_q > grad_t'(255)) begin
            sat_d = 8'd255;
        end else begin
            sat_d = mag_q[7:0];
        end
`ifdef EDGE_THRESH_EN
        edge_d = (sat_d >= bus.thresh) ? 8'd255 : 8'd0;
`else
        edge_d = sat_d;
`endif
    end

    // Gradient, magnitude and output registers; all cleared together on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            gx_q   <= '0;
            gy_q   <= '0;
            mag_q  <= '0;
            edge_q <= 8'd0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            mag_q  <= mag_d;
            edge_q <= edge_d;
        end
    end

    assign bus.gx       = gx_q;
    assign bus.gy       = gy_q;
    assign bus.edge_out = edge_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream with a sample-history reference model.
// The model rebuilds every window from the list of samples accepted since the last reset.
// Build with EDGE_THRESH_EN defined to also exercise the threshold mode.
module tb_sobel_edge_stream;

    localparam int W    = 8;
    localparam int PREC = 16;
    localparam int MAXE = 1024;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sobel_edge_stream_if #(.PRECISION(PREC)) bus ();

    sobel_edge_stream #(.WIDTH(W), .PRECISION(PREC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: per-edge reset flag, threshold, and window results.
    bit rst_h  [MAXE];
    int thr_h  [MAXE];
    int wgx    [MAXE];
    int wgy    [MAXE];
    int wmag   [MAXE];
    int stream [MAXE];
    int n_acc      = 0;
    int edges      = 0;
    int cur_thresh = 0;

    function automatic int tap(input int n, input int r, input int c);
        int idx;
        idx = n - r * W - c;
        return (idx < 0) ? 0 : stream[idx];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int round_edge(input int mag, input int thr);
        int s;
        s = (mag > 255) ? 255 : ((mag < 0) ? 0 : mag);
`ifdef EDGE_THRESH_EN
        return (s >= thr) ? 255 : 0;
`else
        return s + (thr - thr);
`endif
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Model: record each edge and compute the window it forms from the sample history.
    always @(posedge clk) begin
        if (edges < MAXE) begin
            rst_h[edges] = reset;
            thr_h[edges] = cur_thresh;
            if (reset) begin
                n_acc       = 0;
                wgx[edges]  = 0;
                wgy[edges]  = 0;
                wmag[edges] = 0;
            end else begin
                stream[n_acc] = int'(bus.pixel_in);
                wgx[edges] = (tap(n_acc,0,0) + 2*tap(n_acc,1,0) + tap(n_acc,2,0))
                           - (tap(n_acc,0,2) + 2*tap(n_acc,1,2) + tap(n_acc,2,2));
                wgy[edges] = (tap(n_acc,0,0) + 2*tap(n_acc,0,1) + tap(n_acc,0,2))
                           - (tap(n_acc,2,0) + 2*tap(n_acc,2,1) + tap(n_acc,2,2));
                wmag[edges] = iabs(wgx[edges]) + iabs(wgy[edges]);
                n_acc++;
            end
            edges++;
        end
    end

    // Compare: on every falling edge check the outputs produced by the preceding rising edge.
    int  t_c, egx, egy, emag, eedge;
    bit  g_ok, e_ok;
    always @(negedge clk) begin
        if (edges > 0 && edges <= MAXE) begin
            t_c  = edges - 1;
            g_ok = 1'b1;
            e_ok = 1'b1;
            egx  = 0;
            egy  = 0;
            emag = 0;
            eedge = 0;
            if (rst_h[t_c]) begin
                egx = 0;
                egy = 0;
            end else if (t_c >= 1) begin
                egx = wgx[t_c-1];
                egy = wgy[t_c-1];
            end else begin
                g_ok = 1'b0;
            end
            if (rst_h[t_c]) begin
                eedge = 0;
            end else begin
                if (t_c >= 1 && rst_h[t_c-1]) begin
                    emag = 0;
                end else if (t_c >= 2 && rst_h[t_c-2]) begin
                    emag = 0;
                end else if (t_c >= 3) begin
                    emag = wmag[t_c-3];
                end else begin
                    e_ok = 1'b0;
                end
                eedge = round_edge(emag, thr_h[t_c]);
            end
            if (g_ok) begin
                cmp("model_gx", int'(bus.gx), egx);
                cmp("model_gy", int'(bus.gy), egy);
            end
            if (e_ok) begin
                cmp("model_edge", int'(bus.edge_out), eedge);
            end
        end
    end

    task automatic step(input bit r, input logic [7:0] p);
        reset        = r;
        bus.pixel_in = p;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step(1'b1, 8'd0);
        end
    endtask

    task automatic set_thr(input int v);
        cur_thresh = v;
`ifdef EDGE_THRESH_EN
        bus.thresh = v[7:0];
`endif
    endtask

    function automatic logic [7:0] vstep_px(input int i);
        return ((i % W) >= 4) ? 8'd200 : 8'd0;
    endfunction

    function automatic logic [7:0] ramp_px(input int i, input bit rev);
        int v;
        v = (i % W) * 10;
        return rev ? 8'(70 - v) : 8'(v);
    endfunction

    // Ramp run with literal expectations for the steady window w*0=20, w*2=0 (or reversed).
    task automatic run_ramp(input bit rev, input int exp_edge, input string tag);
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, ramp_px(i, rev));
            if (i == 27) begin
                cmp({tag, "_gx"}, int'(bus.gx), rev ? -80 : 80);
                cmp({tag, "_gy"}, int'(bus.gy), 0);
            end
            if (i == 29) cmp({tag, "_edge"}, int'(bus.edge_out), exp_edge);
        end
    endtask

    // Vertical step run; optionally ends with a mid-stream reset and a fresh fill.
    task automatic run_vstep(input int exp_edge, input string tag);
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, vstep_px(i));
            if (i == 30) begin
                cmp({tag, "_gx"}, int'(bus.gx), 800);
                cmp({tag, "_gy"}, int'(bus.gy), 0);
            end
            if (i == 32) cmp({tag, "_edge"}, int'(bus.edge_out), exp_edge);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.pixel_in = 8'd0;
        set_thr(0);

        // Reset state
        do_reset(2);
        cmp("rst_gx", int'(bus.gx), 0);
        cmp("rst_gy", int'(bus.gy), 0);
        cmp("rst_edge", int'(bus.edge_out), 0);

        // Flat field: fill transient, then all zero once the window is full.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'd100);
            if (i == 1) begin
                cmp("flat_first_gx", int'(bus.gx), 100);
                cmp("flat_first_gy", int'(bus.gy), 100);
            end
            if (i == 3) cmp("flat_first_edge", int'(bus.edge_out), 200);
        end
        cmp("flat_gx", int'(bus.gx), 0);
        cmp("flat_gy", int'(bus.gy), 0);
        cmp("flat_edge", int'(bus.edge_out), 0);

        // Vertical step, then a single-cycle mid-stream reset and refill.
        run_vstep(255, "vstep");
        step(1'b1, 8'd200);
        cmp("mid_rst_gx", int'(bus.gx), 0);
        cmp("mid_rst_gy", int'(bus.gy), 0);
        cmp("mid_rst_edge", int'(bus.edge_out), 0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, vstep_px(i + 4));
            if (i == 1) begin
                cmp("refill_gx", int'(bus.gx), 200);
                cmp("refill_gy", int'(bus.gy), 200);
            end
            if (i == 3) cmp("refill_edge", int'(bus.edge_out), 255);
        end

        // Gentle ramps in both directions.
        run_ramp(1'b0, 80, "ramp_up");
        run_ramp(1'b1, 80, "ramp_dn");

        // Horizontal step: line k is 0 when k%3==0, else 50.
        do_reset(2);
        for (int i = 0; i < 48; i++) begin
            step(1'b0, (((i / W) % 3) == 0) ? 8'd0 : 8'd50);
            if (i == 45) begin
                cmp("hstep_gx", int'(bus.gx), 0);
                cmp("hstep_gy", int'(bus.gy), 200);
            end
            if (i == 47) cmp("hstep_edge", int'(bus.edge_out), 200);
        end

`ifdef EDGE_THRESH_EN
        set_thr(100);
        run_ramp(1'b0, 0, "thr100_ramp");
        run_vstep(255, "thr100_vstep");
        set_thr(80);
        run_ramp(1'b0, 255, "thr80_ramp");
`endif

        reset = 1'b0;
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
